steer_cmd_sched: RTL and testbench
==================================

// Module: steer_cmd_sched
// PURPOSE
// - Command scheduler for the steering PWM generator (pwm_dir). Arbitrates steering
//   requests from N_REQ sources, clamps them to the legal servo range, and slew-limits
//   the output. dir_cmd changes only on PWM frame boundaries.
// - Sits between the nav/manual command sources and pwm_dir.data_in. Consumes pwm_dir.dir_rdy.
// - Failsafe: forces neutral steering when no command arrives for TIMEOUT_FRAMES frames.
// PARAMETERS
// - N_REQ          2    number of requesters (1..8)
// - NEUTRAL        150  neutral command (pwm_dir match value 300)
// - MIN_CMD        115  lowest legal command (match 230)
// - MAX_CMD        185  highest legal command (match 370)
// - STEP           4    maximum change of dir_cmd per PWM frame (1..255)
// - TIMEOUT_FRAMES 50   frames without an accepted request before failsafe; 0 disables
// PORTS
// - clk         in   1          system clock
// - rst         in   1          asynchronous reset, active-high
// - req_valid   in   N_REQ      request valid, one bit per source
// - req_data    in   8*N_REQ    requested command; source i occupies bits [8i+7:8i]
// - req_ack     out  N_REQ      one-hot, one-cycle accept pulse
// - dir_rdy     in   1          from pwm_dir; high while the PWM counter is 0
// - dir_cmd     out  8          to pwm_dir.data_in; registered
// - active_src  out  clog2(N_REQ) (min 1)  index of the last accepted source
// - settled     out  1          dir_cmd == target
// - failsafe    out  1          high while in FAILSAFE
// BEHAVIOUR
// - Reset values: dir_cmd=NEUTRAL, target=NEUTRAL, req_ack=0, active_src=0, settled=1,
//   failsafe=0, frame count=0, state=IDLE, dir_rdy_q=0.
// - rst applied mid-slew: all outputs return to reset values immediately (async).
// - frame_tick = dir_rdy & ~dir_rdy_q. Rising-edge detect; exactly one tick per PWM frame.
// - Accept rule: on any cycle where req_valid != 0, the winner w gets req_ack[w]=1 on
//   the next clock edge (registered, 1-cycle latency). On that same edge:
//   - target <= clamp(req_data[w]) to [MIN_CMD, MAX_CMD]
//   - active_src <= w
//   - frame count <= 0
// - Accept is allowed in every state. The source holds valid/data until it sees ack.
//   - An accepted source that is still asserting valid on the ack cycle is not
//     re-granted that cycle.
//   - It may win again on the following cycle.
// - Arbitration (default): fixed priority; the lowest index wins.
// - Slew on frame_tick:
//   - d = target - dir_cmd, computed as 9-bit signed.
//   - If |d| <= STEP: dir_cmd <= target.
//   - Otherwise: dir_cmd <= dir_cmd + STEP if d > 0, or dir_cmd - STEP if d < 0.
//   - Result is never outside [MIN_CMD, MAX_CMD].
//   - No change between ticks.
// - Accept and frame_tick in the same cycle: the slew uses the old target. The new
//   target takes effect at the next tick.
// - FSM states:
//   - IDLE: settled=1. Goes to SLEW when target != dir_cmd.
//   - SLEW: settled=0. Goes to IDLE when dir_cmd reaches target.
//   - FAILSAFE: target forced to NEUTRAL, slew continues. Exits to SLEW/IDLE on the
//     next accept.
// - Timeout:
//   - Frame count increments on each frame_tick and saturates at TIMEOUT_FRAMES.
//   - When the count reaches TIMEOUT_FRAMES (and TIMEOUT_FRAMES != 0), enter FAILSAFE.
//   - An accept in the same cycle wins: no FAILSAFE entry, and the count clears.
// CONFIGURATION
// - STEER_SCHED_RR_EN defined: round-robin arbitration.
//   - Search starts at (active_src+1) mod N_REQ.
//   - The pointer updates only on accept.
//   - Reset pointer gives source 0 first.
// - STEER_SCHED_RR_EN undefined: fixed priority, lowest index wins. Ports are identical.
// TESTING
// - Reset, no requests, 200 frames with TIMEOUT_FRAMES=0 -> dir_cmd=150 throughout,
//   settled=1, no acks.
// - src1 requests 170 at cmd 150 -> ack[1] one cycle later.
//   - Next ticks: dir_cmd = 154,158,...,166,170.
//   - settled rises on the tick that writes 170.
// - src0 requests 60 and src1 requests 250 in the same cycle (fixed prio) -> ack[0] only.
//   - target=115, dir_cmd steps down by 4 per frame to 115, never below 115.
//   - With RR_EN: src1 is acked on the next cycle (target=185).
// - Request 180, then none for 50 frames -> failsafe=1 at tick 50.
//   - dir_cmd slews back to 150.
//   - A request of 120 clears failsafe and sets target 120.
// - Accept coincident with frame_tick at cmd=150, old target=150, new=160 -> dir_cmd
//   stays 150 on that tick and becomes 154 on the next.
// - Assert rst for 1 cycle mid-slew at dir_cmd=162 -> dir_cmd=150, failsafe=0 and
//   req_ack=0 immediately.

Source files
------------

// File: rtl/steer_cmd_if.sv
// -----------------------------------------------------------------------------
// steer_cmd_if
// Bundles the request side and the steering-command side of steer_cmd_sched.
//   master : command sources and the pwm_dir ready strobe (drives requests and
//            dir_rdy, observes acks and the scheduler outputs)
//   slave  : the scheduler itself
// Signals
//   req_valid  [N_REQ]    request valid, one bit per source
//   req_data   [8*N_REQ]  requested command, source i in bits [8i+7:8i]
//   req_ack    [N_REQ]    one-hot, one-cycle accept pulse
//   dir_rdy               high while the pwm_dir counter is 0
//   dir_cmd    [8]        command to pwm_dir.data_in
//   active_src [AW]       index of the last accepted source
//   settled               dir_cmd equals the current target
//   failsafe              high while the command timeout is active
// -----------------------------------------------------------------------------
interface steer_cmd_if #(
    parameter int N_REQ = 2
);
    localparam int AW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ack;
    logic               dir_rdy;
    logic [7:0]         dir_cmd;
    logic [AW-1:0]      active_src;
    logic               settled;
    logic               failsafe;

    modport master (
        output req_valid, req_data, dir_rdy,
        input  req_ack, dir_cmd, active_src, settled, failsafe
    );

    modport slave (
        input  req_valid, req_data, dir_rdy,
        output req_ack, dir_cmd, active_src, settled, failsafe
    );
endinterface

// File: rtl/steer_cmd_sched.sv
// -----------------------------------------------------------------------------
// steer_cmd_sched
// Steering command scheduler in front of pwm_dir. Arbitrates requests from
// N_REQ sources, clamps the winner to [MIN_CMD, MAX_CMD] and slews dir_cmd
// toward that target by at most STEP per PWM frame. dir_cmd only moves on a
// frame boundary (rising edge of dir_rdy). If no request is accepted for
// TIMEOUT_FRAMES frames the target is forced to NEUTRAL (failsafe) until the
// next accept. TIMEOUT_FRAMES = 0 disables the timeout.
//
// Ports
//   clk   system clock
//   rst   asynchronous reset, active-high
//   bus   steer_cmd_if.slave (requests, acks, dir_rdy, dir_cmd, status)
//
// Configuration
//   STEER_SCHED_RR_EN  defined   : round-robin arbitration, search starts one
//                                  past the last accepted source
//                      undefined : fixed priority, lowest index wins
// -----------------------------------------------------------------------------
module steer_cmd_sched #(
    parameter int N_REQ          = 2,
    parameter int NEUTRAL        = 150,
    parameter int MIN_CMD        = 115,
    parameter int MAX_CMD        = 185,
    parameter int STEP           = 4,
    parameter int TIMEOUT_FRAMES = 50
) (
    input logic       clk,
    input logic       rst,
    steer_cmd_if.slave bus
);
    localparam int AW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

    localparam logic [7:0]    NEUTRAL_C = 8'(NEUTRAL);
    localparam logic [7:0]    MIN_C     = 8'(MIN_CMD);
    localparam logic [7:0]    MAX_C     = 8'(MAX_CMD);
    localparam logic [7:0]    STEP_C    = 8'(STEP);
    localparam logic [CW-1:0] TMO_C     = CW'(TIMEOUT_FRAMES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SLEW     = 2'd1,
        FAILSAFE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              dir_rdy_q;
    logic              frame_tick;
    logic [7:0]        target, target_nxt;
    logic [7:0]        dir_cmd_q, dir_nxt, slew_val;
    logic [N_REQ-1:0]  ack_q, elig;
    logic [AW-1:0]     active_q, win;
    logic              found;
    logic [CW-1:0]     frame_cnt;
    logic              timeout_hit;
    logic [7:0]        win_data, win_clamped;
    logic signed [8:0] diff;
    logic [8:0]        mag;

    assign frame_tick = bus.dir_rdy & ~dir_rdy_q;

    // A source still holding valid during its own ack cycle is masked so it
    // cannot be granted twice for one request.
    assign elig = bus.req_valid & ~ack_q;

    // ---------------------------------------------------------------- arbiter
`ifdef STEER_SCHED_RR_EN
    // Last-granted pointer; resets to N_REQ-1 so source 0 is searched first.
    logic [AW-1:0] rr_last;

    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_last) + 1 + k) % N_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = AW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= AW'(N_REQ - 1);
        end else if (found) begin
            rr_last <= win;
        end
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (elig[k]) begin
                found = 1'b1;
                win   = AW'(k);
            end
        end
    end
`endif

    // ------------------------------------------------------- clamp and slew
    always_comb begin
        win_data = bus.req_data[int'(win) * 8 +: 8];
        if (win_data < MIN_C) begin
            win_clamped = MIN_C;
        end else if (win_data > MAX_C) begin
            win_clamped = MAX_C;
        end else begin
            win_clamped = win_data;
        end
    end

    // The slew always uses the registered target, so an accept coinciding
    // with a frame tick only takes effect on the following tick.
    always_comb begin
        diff = $signed({1'b0, target}) - $signed({1'b0, dir_cmd_q});
        mag  = diff[8] ? 9'(-diff) : 9'(diff);
        if (mag <= 9'(STEP)) begin
            slew_val = target;
        end else if (!diff[8]) begin
            slew_val = dir_cmd_q + STEP_C;
        end else begin
            slew_val = dir_cmd_q - STEP_C;
        end
        dir_nxt = frame_tick ? slew_val : dir_cmd_q;
    end

    // Timeout fires on the tick that would bring the count to TIMEOUT_FRAMES;
    // an accept in the same cycle takes precedence.
    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT_FRAMES != 0) begin
            timeout_hit = frame_tick && !found &&
                          (int'(frame_cnt) + 1 >= TIMEOUT_FRAMES);
        end
    end

    always_comb begin
        if (found) begin
            target_nxt = win_clamped;
        end else if (timeout_hit || state == FAILSAFE) begin
            target_nxt = NEUTRAL_C;
        end else begin
            target_nxt = target;
        end
    end

    // -------------------------------------------------------------- FSM
    always_comb begin
        state_nxt = state;
        if (!found && (timeout_hit || state == FAILSAFE)) begin
            state_nxt = FAILSAFE;
        end else if (target_nxt != dir_nxt) begin
            state_nxt = SLEW;
        end else begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of ordering.
            dir_rdy_q <= 1'b0;
            dir_cmd_q <= NEUTRAL_C;
            target    <= NEUTRAL_C;
            ack_q     <= '0;
            active_q  <= '0;
            frame_cnt <= '0;
        end else begin
            dir_rdy_q <= bus.dir_rdy;
            dir_cmd_q <= dir_nxt;
            target    <= target_nxt;
            ack_q     <= found ? (N_REQ'(1) << win) : '0;
            if (found) begin
                active_q <= win;
            end
            if (found) begin
                frame_cnt <= '0;
            end else if (frame_tick && frame_cnt != TMO_C) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign bus.req_ack    = ack_q;
    assign bus.dir_cmd    = dir_cmd_q;
    assign bus.active_src = active_q;
    assign bus.failsafe   = (state == FAILSAFE);
    assign bus.settled    = (state == IDLE) ||
                            ((state == FAILSAFE) && (dir_cmd_q == target));
endmodule

// File: tb/tb_steer_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_steer_cmd_sched
// Directed bench for steer_cmd_sched. The main DUT uses default parameters;
// a second instance with TIMEOUT_FRAMES = 0 sees the same dir_rdy but no
// requests. Inputs are driven and outputs sampled 1 time unit after the
// rising clock edge.
// -----------------------------------------------------------------------------
module tb_steer_cmd_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    steer_cmd_if #(.N_REQ(2)) bus ();
    steer_cmd_if #(.N_REQ(2)) bus_nt ();

    assign bus_nt.dir_rdy   = bus.dir_rdy;
    assign bus_nt.req_valid = '0;
    assign bus_nt.req_data  = '0;

    steer_cmd_sched #(.N_REQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    steer_cmd_sched #(.N_REQ(2), .TIMEOUT_FRAMES(0)) dut_nt (
        .clk (clk),
        .rst (rst),
        .bus (bus_nt.slave)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One PWM frame: dir_rdy rises (tick on the next edge), then falls.
    task automatic frame();
        bus.dir_rdy = 1'b1;
        cycle();
        bus.dir_rdy = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.dir_rdy   = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    // Expected next dir_cmd after one tick (STEP = 4).
    function automatic logic [7:0] toward(logic [7:0] cur, logic [7:0] tgt);
        if (cur < tgt) return (tgt - cur <= 8'd4) ? tgt : cur + 8'd4;
        return (cur - tgt <= 8'd4) ? tgt : cur - 8'd4;
    endfunction

    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.dir_rdy   = 1'b0;
        rst = 1'b1;
        cycle();
        checks++;
        if (bus.dir_cmd !== 8'd150) begin
            errors++; $display("FAIL reset_dir_cmd: got %0d expected 150", bus.dir_cmd);
        end
        checks++;
        if (bus.req_ack !== 2'b00) begin
            errors++; $display("FAIL reset_ack: got %b expected 00", bus.req_ack);
        end
        checks++;
        if (bus.active_src !== 1'b0 || bus.settled !== 1'b1 || bus.failsafe !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: src=%b settled=%b failsafe=%b expected 0 1 0",
                     bus.active_src, bus.settled, bus.failsafe);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_idle_no_timeout();
        int bad = 0;
        do_reset();
        for (int f = 0; f < 200; f++) begin
            frame();
            checks++;
            if (bus_nt.dir_cmd !== 8'd150 || bus_nt.settled !== 1'b1 ||
                bus_nt.req_ack !== 2'b00 || bus_nt.failsafe !== 1'b0) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL idle_frame%0d: cmd=%0d settled=%b ack=%b fs=%b expected 150 1 00 0",
                             f, bus_nt.dir_cmd, bus_nt.settled, bus_nt.req_ack, bus_nt.failsafe);
            end
        end
        // Same idle stimulus on the timeout-enabled DUT must end in failsafe.
        checks++;
        if (bus.failsafe !== 1'b1 || bus.dir_cmd !== 8'd150) begin
            errors++;
            $display("FAIL idle_timeout_dut: failsafe=%b cmd=%0d expected 1 150",
                     bus.failsafe, bus.dir_cmd);
        end
    endtask

    task automatic test_slew_up();
        logic [7:0] exp_seq [5] = '{8'd154, 8'd158, 8'd162, 8'd166, 8'd170};
        do_reset();
        bus.req_valid = 2'b10;
        bus.req_data  = {8'd170, 8'd0};
        cycle();
        checks++;
        if (bus.req_ack !== 2'b10 || bus.active_src !== 1'b1) begin
            errors++;
            $display("FAIL src1_ack: ack=%b src=%b expected 10 1", bus.req_ack, bus.active_src);
        end
        bus.req_valid = '0;
        cycle();
        checks++;
        if (bus.req_ack !== 2'b00 || bus.settled !== 1'b0 || bus.dir_cmd !== 8'd150) begin
            errors++;
            $display("FAIL src1_after_ack: ack=%b settled=%b cmd=%0d expected 00 0 150",
                     bus.req_ack, bus.settled, bus.dir_cmd);
        end
        for (int i = 0; i < 5; i++) begin
            frame();
            checks++;
            if (bus.dir_cmd !== exp_seq[i] || bus.settled !== (i == 4)) begin
                errors++;
                $display("FAIL slew_up%0d: cmd=%0d settled=%b expected %0d %b",
                         i, bus.dir_cmd, bus.settled, exp_seq[i], (i == 4));
            end
        end
    endtask

    task automatic test_clamp_prio();
        logic [7:0] exp;
        logic [7:0] tgt;
        do_reset();
        bus.req_valid = 2'b11;
        bus.req_data  = {8'd250, 8'd60};
        cycle();
        checks++;
        if (bus.req_ack !== 2'b01 || bus.active_src !== 1'b0) begin
            errors++;
            $display("FAIL prio_ack: ack=%b src=%b expected 01 0", bus.req_ack, bus.active_src);
        end
`ifdef STEER_SCHED_RR_EN
        bus.req_valid = 2'b10;
        cycle();
        checks++;
        if (bus.req_ack !== 2'b10 || bus.active_src !== 1'b1) begin
            errors++;
            $display("FAIL rr_ack: ack=%b src=%b expected 10 1", bus.req_ack, bus.active_src);
        end
        bus.req_valid = '0;
        tgt = 8'd185;
`else
        // Both sources withdraw; only source 0 was granted.
        bus.req_valid = '0;
        tgt = 8'd115;
`endif
        cycle();
        checks++;
        if (bus.req_ack !== 2'b00) begin
            errors++; $display("FAIL prio_single_ack: ack=%b expected 00", bus.req_ack);
        end
        exp = 8'd150;
        for (int i = 0; i < 11; i++) begin
            frame();
            exp = toward(exp, tgt);
            checks++;
            if (bus.dir_cmd !== exp || bus.dir_cmd < 8'd115 || bus.dir_cmd > 8'd185) begin
                errors++;
                $display("FAIL clamp_slew%0d: cmd=%0d expected %0d", i, bus.dir_cmd, exp);
            end
        end
        checks++;
        if (bus.settled !== 1'b1 || bus.dir_cmd !== tgt) begin
            errors++;
            $display("FAIL clamp_final: cmd=%0d settled=%b expected %0d 1",
                     bus.dir_cmd, bus.settled, tgt);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] exp;
        do_reset();
        bus.req_valid = 2'b01;
        bus.req_data  = {8'd0, 8'd180};
        cycle();
        bus.req_valid = '0;
        cycle();
        exp = 8'd150;
        for (int t = 1; t <= 50; t++) begin
            frame();
            exp = toward(exp, 8'd180);
            if (t == 49) begin
                checks++;
                if (bus.failsafe !== 1'b0) begin
                    errors++; $display("FAIL tmo_tick49: failsafe=%b expected 0", bus.failsafe);
                end
            end
        end
        checks++;
        if (bus.failsafe !== 1'b1 || bus.dir_cmd !== 8'd180 || bus.settled !== 1'b0) begin
            errors++;
            $display("FAIL tmo_tick50: failsafe=%b cmd=%0d settled=%b expected 1 180 0",
                     bus.failsafe, bus.dir_cmd, bus.settled);
        end
        for (int i = 0; i < 8; i++) begin
            frame();
            exp = toward(exp, 8'd150);
            checks++;
            if (bus.dir_cmd !== exp || bus.failsafe !== 1'b1) begin
                errors++;
                $display("FAIL fs_slew%0d: cmd=%0d fs=%b expected %0d 1",
                         i, bus.dir_cmd, bus.failsafe, exp);
            end
        end
        checks++;
        if (bus.settled !== 1'b1) begin
            errors++; $display("FAIL fs_settled: settled=%b expected 1", bus.settled);
        end
        bus.req_valid = 2'b10;
        bus.req_data  = {8'd120, 8'd0};
        cycle();
        checks++;
        if (bus.failsafe !== 1'b0 || bus.req_ack !== 2'b10 || bus.settled !== 1'b0) begin
            errors++;
            $display("FAIL fs_exit: failsafe=%b ack=%b settled=%b expected 0 10 0",
                     bus.failsafe, bus.req_ack, bus.settled);
        end
        bus.req_valid = '0;
        cycle();
        for (int i = 0; i < 8; i++) begin
            frame();
            exp = toward(exp, 8'd120);
        end
        checks++;
        if (bus.dir_cmd !== 8'd120 || exp !== 8'd120 || bus.settled !== 1'b1) begin
            errors++;
            $display("FAIL fs_retarget: cmd=%0d settled=%b expected 120 1",
                     bus.dir_cmd, bus.settled);
        end
    endtask

    task automatic test_coincident();
        do_reset();
        bus.req_valid = 2'b01;
        bus.req_data  = {8'd0, 8'd160};
        bus.dir_rdy   = 1'b1;
        cycle();
        checks++;
        if (bus.dir_cmd !== 8'd150 || bus.req_ack !== 2'b01) begin
            errors++;
            $display("FAIL coincident_tick: cmd=%0d ack=%b expected 150 01",
                     bus.dir_cmd, bus.req_ack);
        end
        bus.req_valid = '0;
        bus.dir_rdy   = 1'b0;
        cycle();
        cycle();
        frame();
        checks++;
        if (bus.dir_cmd !== 8'd154) begin
            errors++; $display("FAIL coincident_next: cmd=%0d expected 154", bus.dir_cmd);
        end
    endtask

    task automatic test_reset_mid_slew();
        do_reset();
        bus.req_valid = 2'b01;
        bus.req_data  = {8'd0, 8'd170};
        cycle();
        bus.req_valid = '0;
        cycle();
        frame();
        frame();
        frame();
        checks++;
        if (bus.dir_cmd !== 8'd162) begin
            errors++; $display("FAIL midslew_pre: cmd=%0d expected 162", bus.dir_cmd);
        end
        // Re-request so an ack pulse is live when reset hits.
        bus.req_valid = 2'b01;
        cycle();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.dir_cmd !== 8'd150 || bus.failsafe !== 1'b0 ||
            bus.req_ack !== 2'b00 || bus.settled !== 1'b1) begin
            errors++;
            $display("FAIL midslew_rst: cmd=%0d fs=%b ack=%b settled=%b expected 150 0 00 1",
                     bus.dir_cmd, bus.failsafe, bus.req_ack, bus.settled);
        end
        bus.req_valid = '0;
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.dir_rdy   = 1'b0;
        #1;
        test_reset();
        test_idle_no_timeout();
        test_slew_up();
        test_clamp_prio();
        test_timeout();
        test_coincident();
        test_reset_mid_slew();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
